// File: rtl/core_struct_pkg.sv
//------------------------------------------------------------------------------
// core_struct_pkg : common beat structure exchanged between core packet stages
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package core_struct_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        error;
    logic [7:0]  frm_dbg_id;
  } core_avl_t;

endpackage

`default_nettype wire

// File: rtl/tych_fwd_pkg.sv
//------------------------------------------------------------------------------
// tych_fwd_pkg : framing FSM encoding and helpers for tych_fwd_buf
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tych_fwd_pkg;

  typedef enum logic [0:0] {
    FRM_IDLE = 1'b0,
    FRM_IN   = 1'b1
  } frm_state_t;

  // Occupancy needs one extra bit so that a completely full buffer is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Increment that holds at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [32:0] max_v;
    max_v = (33'd1 << w) - 33'd1;
    return (v == max_v[31:0]) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tych_fwd_fifo.sv
//------------------------------------------------------------------------------
// tych_fwd_fifo : single-channel core_avl_t elastic buffer with registered ready
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tych_fwd_fifo
  import core_struct_pkg::*;
  import tych_fwd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  core_avl_t                 push_beat,
  output logic                      in_ready,
  input  logic                      out_ready,
  output core_avl_t                 head,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic          in_ready_q, in_ready_d;
  core_avl_t     mem_q [DEPTH];
  core_avl_t     mem_d [DEPTH];
  logic [LW-1:0] level_d;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push & in_ready_q;
  assign do_pop  = ~empty & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_beat;
      wr_ptr_d                = wr_ptr_q + LW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + LW'(1);
    end
    level_d    = wr_ptr_d - rd_ptr_d;
    // Ready is a flop of next-cycle fullness, so a pop never frees a slot combinationally.
    in_ready_d = (level_d != LW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head       = mem_q[rd_ptr_q[AW-1:0]];
    head.valid = mem_q[rd_ptr_q[AW-1:0]].valid & ~empty;
  end

  assign in_ready = in_ready_q;
  assign level    = wr_ptr_q - rd_ptr_q;

endmodule

`default_nettype wire

// File: rtl/tych_fwd_buf.sv
//------------------------------------------------------------------------------
// tych_fwd_buf : per-port elastic forwarder with optional SOP/EOP framing check
// Optional feature macro: TYCH_FWD_FRM_CHK_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tych_fwd_buf
  import core_struct_pkg::*;
  import tych_fwd_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  core_avl_t [NUM_PORTS-1:0]               core_avl_in,
  output logic      [NUM_PORTS-1:0]               core_avl_in_ready,
  output core_avl_t [NUM_PORTS-1:0]               core_avl_out,
  input  logic      [NUM_PORTS-1:0]               core_avl_out_ready,
  output logic      [NUM_PORTS-1:0][lvl_w(DEPTH)-1:0] level,
  output logic      [NUM_PORTS-1:0][CNT_W-1:0]    frm_err_cnt
);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic      accept;
    logic      wr_en;
    core_avl_t wr_beat;

    assign accept = core_avl_in[i].valid & core_avl_in_ready[i];

`ifdef TYCH_FWD_FRM_CHK_EN
    frm_state_t       frm_st_q, frm_st_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Orphans are handshaken but never written; a premature SOP is kept but flagged.
    always_comb begin
      frm_st_d  = frm_st_q;
      err_cnt_d = err_cnt_q;
      wr_en     = 1'b0;
      wr_beat   = core_avl_in[i];
      if (accept) begin
        if (frm_st_q == FRM_IDLE) begin
          if (core_avl_in[i].sop) begin
            wr_en    = 1'b1;
            frm_st_d = core_avl_in[i].eop ? FRM_IDLE : FRM_IN;
          end else begin
            err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
          end
        end else begin
          wr_en    = 1'b1;
          frm_st_d = core_avl_in[i].eop ? FRM_IDLE : FRM_IN;
          if (core_avl_in[i].sop) begin
            wr_beat.error = 1'b1;
            err_cnt_d     = CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        frm_st_q  <= FRM_IDLE;
        err_cnt_q <= '0;
      end else begin
        frm_st_q  <= frm_st_d;
        err_cnt_q <= err_cnt_d;
      end
    end

    assign frm_err_cnt[i] = err_cnt_q;
`else
    assign wr_en          = accept;
    assign wr_beat        = core_avl_in[i];
    assign frm_err_cnt[i] = '0;
`endif

    tych_fwd_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .push      (wr_en),
      .push_beat (wr_beat),
      .in_ready  (core_avl_in_ready[i]),
      .out_ready (core_avl_out_ready[i]),
      .head      (core_avl_out[i]),
      .level     (level[i])
    );
  end

endmodule

`default_nettype wire
